// File: rtl/fpnew_lane_sequencer.sv
// fpnew_lane_sequencer: takes one Width-bit SIMD operation, issues its
// FpWidth-bit lanes in beats over NumUnits shared lane units, and reassembles
// the returned beats into a single result.
//
// Handshake semantics (all ports): a transfer happens on a rising clk_i edge
// where valid and ready are both high. Valid never depends combinationally
// on ready. Once asserted, valid stays high with stable payload until the
// transfer or a flush. The unit issue/return handshakes are shared by every
// unit: unit_in_ready_i is the AND of all unit readies, and unit_out_valid_i
// marks a full beat returning in issue order.
module fpnew_lane_sequencer #(
  parameter int unsigned Width                  = 64,
  parameter int unsigned FpWidth                = 16,
  parameter int unsigned NumOperands            = 3,
  parameter int unsigned NumUnits               = 2,
  parameter type         TagType                = logic,
  parameter bit          CompressedVecCmpResult = 1'b0,
  localparam int unsigned NUM_LANES = Width / FpWidth,
  localparam int unsigned NUM_BEATS = (NUM_LANES + NumUnits - 1) / NumUnits
) (
  input  logic                                            clk_i,
  input  logic                                            rst_ni,
  input  logic [NumOperands-1:0][Width-1:0]               operands_i,
  input  logic                                            vectorial_op_i,
  input  logic                                            cmp_op_i,
  input  logic [NUM_LANES-1:0]                            simd_mask_i,
  input  TagType                                          tag_i,
  input  logic                                            in_valid_i,
  output logic                                            in_ready_o,
  input  logic                                            flush_i,
  output logic [Width-1:0]                                result_o,
  output logic [4:0]                                      status_o,
  output logic                                            extension_bit_o,
  output TagType                                          tag_o,
  output logic                                            out_valid_o,
  input  logic                                            out_ready_i,
  output logic                                            busy_o,
  output logic [NumUnits-1:0][NumOperands-1:0][FpWidth-1:0] unit_operands_o,
  output logic [NumUnits-1:0]                             unit_lane_en_o,
  output logic [NumUnits-1:0]                             unit_mask_o,
  output logic                                            unit_in_valid_o,
  input  logic                                            unit_in_ready_i,
  input  logic [NumUnits-1:0][FpWidth-1:0]                unit_result_i,
  input  logic [NumUnits-1:0][4:0]                        unit_status_i,
  input  logic                                            unit_ext_bit_i,
  input  logic                                            unit_out_valid_i,
  output logic                                            unit_out_ready_o,
  output logic                                            unit_flush_o
);

  localparam int unsigned CNT_W  = $clog2(NUM_BEATS + 1);
  localparam int unsigned LIDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_e;

  typedef logic [NUM_LANES-1:0][FpWidth-1:0] lanes_t;

  state_e                    state_q;
  lanes_t [NumOperands-1:0]  ops_q;
  lanes_t                    buf_q, buf_d;
  logic [NUM_LANES-1:0]      mask_q;
  TagType                    tag_q;
  logic                      vec_q, cmp_q, ext_q;
  logic [4:0]                status_q, status_d;
  logic [CNT_W-1:0]          beats_q, issue_cnt_q, ret_cnt_q;

  logic                      issue_active, issue_hs, ret_active, ret_hs;
  logic [31:0]               lane_i, lane_r;
  logic [LIDX_W-1:0]         idx_i, idx_r;

  // A lane is computed when it exists and the op is vectorial, or it is lane 0.
  function automatic logic lane_en(input logic [31:0] lane, input logic vec);
    return (lane < NUM_LANES) && (vec || (lane == 32'd0));
  endfunction

  assign in_ready_o       = (state_q == IDLE);
  assign busy_o           = (state_q != IDLE);
  assign out_valid_o      = (state_q == OUT);
  assign unit_flush_o     = flush_i;

  assign issue_active     = (state_q == RUN) && (issue_cnt_q < beats_q);
  assign issue_hs         = issue_active && unit_in_ready_i;
  assign unit_in_valid_o  = issue_active;

  // In IDLE, stale returns from a flushed operation are drained and dropped.
  assign ret_active       = (state_q == RUN) && (ret_cnt_q < beats_q);
  assign ret_hs           = ret_active && unit_out_valid_i;
  assign unit_out_ready_o = (state_q == IDLE) || ret_active;

  assign status_o         = status_q;
  assign extension_bit_o  = ext_q;
  assign tag_o            = tag_q;

  // Map the lanes of the current issue beat onto the physical units.
  always_comb begin
    unit_operands_o = '0;
    unit_lane_en_o  = '0;
    unit_mask_o     = '0;
    lane_i          = '0;
    idx_i           = '0;
    for (int unsigned u = 0; u < NumUnits; u++) begin
      lane_i = 32'(issue_cnt_q) * NumUnits + u;
      idx_i  = lane_i[LIDX_W-1:0];
      if (issue_active && lane_en(lane_i, vec_q)) begin
        unit_lane_en_o[u] = 1'b1;
        unit_mask_o[u]    = mask_q[idx_i];
        for (int unsigned o = 0; o < NumOperands; o++) begin
          unit_operands_o[u][o] = ops_q[o][idx_i];
        end
      end
    end
  end

  // Merge a returning beat into the lane buffer and the status accumulator.
  always_comb begin
    buf_d    = buf_q;
    status_d = status_q;
    lane_r   = '0;
    idx_r    = '0;
    for (int unsigned u = 0; u < NumUnits; u++) begin
      lane_r = 32'(ret_cnt_q) * NumUnits + u;
      idx_r  = lane_r[LIDX_W-1:0];
      if (lane_en(lane_r, vec_q)) begin
        buf_d[idx_r] = unit_result_i[u];
        status_d     = status_d | (unit_status_i[u] & {5{mask_q[idx_r]}});
      end
    end
  end

  // Assemble the result: uncomputed lanes are boxed with the extension bit,
  // vector compares optionally pack one bit per lane.
  always_comb begin
    result_o = '0;
    if (CompressedVecCmpResult && cmp_q && vec_q) begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        result_o[l] = buf_q[l][0];
      end
    end else begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        result_o[l*FpWidth +: FpWidth] = (vec_q || (l == 0)) ? buf_q[l] : {FpWidth{ext_q}};
      end
    end
  end

  // Sequencer FSM: accept, issue/collect beats, hold the result until taken.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ops_q       <= '0;
      buf_q       <= '0;
      mask_q      <= '0;
      tag_q       <= '0;
      vec_q       <= 1'b0;
      cmp_q       <= 1'b0;
      ext_q       <= 1'b0;
      status_q    <= '0;
      beats_q     <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
    end else if (flush_i) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            state_q     <= RUN;
            ops_q       <= operands_i;
            mask_q      <= simd_mask_i;
            tag_q       <= tag_i;
            vec_q       <= vectorial_op_i;
            cmp_q       <= cmp_op_i;
            beats_q     <= vectorial_op_i ? CNT_W'(NUM_BEATS) : CNT_W'(1);
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            buf_q       <= '0;
            status_q    <= '0;
            ext_q       <= 1'b0;
          end
        end
        RUN: begin
          if (issue_hs) begin
            issue_cnt_q <= issue_cnt_q + 1'b1;
          end
          if (ret_hs) begin
            buf_q     <= buf_d;
            status_q  <= status_d;
            ret_cnt_q <= ret_cnt_q + 1'b1;
            if (ret_cnt_q == '0) begin
              ext_q <= unit_ext_bit_i;
            end
            if (ret_cnt_q == beats_q - 1'b1) begin
              state_q <= OUT;
            end
          end
        end
        OUT: begin
          if (out_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
